serial_xor_parity_ctrl: RTL and testbench

- Controller that sequences a single shared 1-bit XOR cell over a WIDTH-bit word, one bit per clock, to produce the word's parity.
- Wraps the gate-level XOR with a load/shift/accumulate FSM and valid/ready handshakes on both sides.
- Intended as the serial parity unit feeding downstream checkers where area matters more than latency.

---
 rtl/serial_xor_parity_ctrl_if.sv | 41 ++++
 rtl/serial_xor_parity_ctrl.sv | 114 +++++++++++
 tb/tb_serial_xor_parity_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_xor_parity_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_xor_parity_ctrl_if
//   Handshake bundle for the serial parity controller.
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both high. A producer keeps valid (and its data) stable
//   until that edge; ready may be asserted independently of valid.
//
//   Signals:
//     in_valid   producer -> ctrl   in_data holds a word to reduce
//     in_ready   ctrl -> producer   controller can accept a word (IDLE only)
//     in_data    producer -> ctrl   WIDTH-bit word
//     out_valid  ctrl -> consumer   out_parity holds a result
//     out_ready  consumer -> ctrl   consumer takes the result
//     out_parity ctrl -> consumer   parity of the accepted word
//     busy       ctrl -> anyone     a word is being reduced or awaits pickup
//
//   Modports: master = the side that feeds words and takes results,
//             slave  = the controller.
// -----------------------------------------------------------------------------
interface serial_xor_parity_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic             busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_parity, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_parity, busy
    );
endinterface

// File: rtl/serial_xor_parity_ctrl.sv
// -----------------------------------------------------------------------------
// serial_xor_parity_ctrl
//   Computes the parity of a WIDTH-bit word with one shared XOR cell, one bit
//   per clock. A word is captured in IDLE, shifted out LSB first through the
//   XOR/accumulator for exactly WIDTH cycles, and the result is then held in
//   DONE until the consumer takes it.
//
//   Parameters:
//     WIDTH  bits per word (1..64)
//     ODD    0: even parity (XOR of all bits), 1: inverted result
//
//   Ports:
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset
//     bus      handshake bundle (slave side), see serial_xor_parity_ctrl_if
//     state_o  current FSM state for observation (0 IDLE, 1 SHIFT, 2 DONE)
//
//   All outputs come straight from registers, so in_valid/out_ready never
//   reach an output combinationally.
// -----------------------------------------------------------------------------
module serial_xor_parity_ctrl #(
    parameter int WIDTH = 8,
    parameter int ODD   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    serial_xor_parity_ctrl_if.slave       bus,
    output logic [1:0]                    state_o
);

    localparam int             CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
    localparam logic           ODD_BIT = (ODD != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  sr_q;
    logic              acc_q;
    logic [CW-1:0]     cnt_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              out_parity_q;
    logic              busy_q;

    // The single shared XOR cell.
    logic acc_d;
    assign acc_d = acc_q ^ sr_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_parity_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sr_q       <= bus.in_data;
                        acc_q      <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= SHIFT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    sr_q  <= sr_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                    // The last bit goes through the cell on this edge, so the
                    // published result uses acc_d rather than acc_q.
                    if (cnt_q == LAST) begin
                        state_q      <= DONE;
                        out_valid_q  <= 1'b1;
                        out_parity_q <= acc_d ^ ODD_BIT;
                    end
                end
                DONE: begin
                    // out_parity_q is left untouched so it stays stable while
                    // out_valid is high.
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_parity = out_parity_q;
    assign bus.busy       = busy_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_serial_xor_parity_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_xor_parity_ctrl
//   Three controllers share clk/rst_n:
//     dut 0: WIDTH=8 ODD=0, dut 1: WIDTH=8 ODD=1, dut 2: WIDTH=1 ODD=0.
//   A reference model tracks, per dut, which phase of its life a word is in
//   (waiting, being reduced for WIDTH cycles, waiting for pickup) and the
//   parity of the accepted word computed as a population count.
// -----------------------------------------------------------------------------
module tb_serial_xor_parity_ctrl;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus and observation arrays ----------------
    logic        in_valid  [3];
    logic [63:0] in_data   [3];
    logic        out_ready [3];
    logic        d_in_ready  [3];
    logic        d_out_valid [3];
    logic        d_out_parity[3];
    logic        d_busy      [3];
    logic [1:0]  d_state     [3];

    int widths [3] = '{8, 8, 1};
    int odds   [3] = '{0, 1, 0};

    serial_xor_parity_ctrl_if #(.WIDTH(8)) if0 ();
    serial_xor_parity_ctrl_if #(.WIDTH(8)) if1 ();
    serial_xor_parity_ctrl_if #(.WIDTH(1)) if2 ();

    assign if0.in_valid  = in_valid[0];
    assign if0.in_data   = in_data[0][7:0];
    assign if0.out_ready = out_ready[0];
    assign if1.in_valid  = in_valid[1];
    assign if1.in_data   = in_data[1][7:0];
    assign if1.out_ready = out_ready[1];
    assign if2.in_valid  = in_valid[2];
    assign if2.in_data   = in_data[2][0:0];
    assign if2.out_ready = out_ready[2];

    assign d_in_ready[0] = if0.in_ready;   assign d_out_valid[0] = if0.out_valid;
    assign d_out_parity[0] = if0.out_parity; assign d_busy[0] = if0.busy;
    assign d_in_ready[1] = if1.in_ready;   assign d_out_valid[1] = if1.out_valid;
    assign d_out_parity[1] = if1.out_parity; assign d_busy[1] = if1.busy;
    assign d_in_ready[2] = if2.in_ready;   assign d_out_valid[2] = if2.out_valid;
    assign d_out_parity[2] = if2.out_parity; assign d_busy[2] = if2.busy;

    serial_xor_parity_ctrl #(.WIDTH(8), .ODD(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .state_o(d_state[0]));
    serial_xor_parity_ctrl #(.WIDTH(8), .ODD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .state_o(d_state[1]));
    serial_xor_parity_ctrl #(.WIDTH(1), .ODD(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave), .state_o(d_state[2]));

    // ---------------- counters ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0b required=%0b t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0d required=%0d t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 waiting for a word, 1 reducing (rem cycles left), 2 result held
    int   ph  [3] = '{0, 0, 0};
    int   rem [3] = '{0, 0, 0};
    logic par [3] = '{1'b0, 1'b0, 1'b0};

    function automatic logic ref_parity(input logic [63:0] w, input int width, input int odd);
        logic [63:0] m;
        m = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return logic'(($countones(w & m) % 2) == 1) ^ logic'(odd != 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                ph[k]  = 0;
                rem[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                case (ph[k])
                    0: if (in_valid[k]) begin
                        par[k] = ref_parity(in_data[k], widths[k], odds[k]);
                        rem[k] = widths[k];
                        ph[k]  = 1;
                    end
                    1: begin
                        rem[k] = rem[k] - 1;
                        if (rem[k] == 0) ph[k] = 2;
                    end
                    default: if (out_ready[k]) ph[k] = 0;
                endcase
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("in_ready", k, d_in_ready[k], ph[k] == 0);
            chk("out_valid", k, d_out_valid[k], ph[k] == 2);
            chk("busy", k, d_busy[k], ph[k] != 0);
            if (ph[k] == 2) chk("out_parity", k, d_out_parity[k], par[k]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b0;
        end
    endtask

    // Offer one word, wait for the result, hold it for 'hold' cycles, take it.
    task automatic send(input int k, input logic [63:0] w, input int hold,
                        output logic p, output int lat);
        int n;
        @(negedge clk);
        in_valid[k] = 1'b1;
        in_data[k]  = w;
        n = 0;
        while (!d_in_ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", k, 1'b1, 1'b0);
        @(negedge clk);
        in_valid[k] = 1'b0;
        lat = 0;
        while (!d_out_valid[k] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) chk("result_timeout", k, 1'b1, 1'b0);
        repeat (hold) @(negedge clk);
        p = d_out_parity[k];
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    logic [63:0] words8 [5] = '{64'h00, 64'h01, 64'hA5, 64'hFF, 64'h80};
    logic        pars8  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        logic p;
        int   lat;
        int   n;
        idle_all();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", k, d_in_ready[k], 1'b1);
            chk("rst_out_valid", k, d_out_valid[k], 1'b0);
            chk("rst_out_parity", k, d_out_parity[k], 1'b0);
            chk("rst_busy", k, d_busy[k], 1'b0);
            chk_int("rst_state", k, int'(d_state[k]), 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed words, even parity, WIDTH=8
        for (int i = 0; i < 5; i++) begin
            send(0, words8[i], 0, p, lat);
            chk("dir_parity", 0, p, pars8[i]);
            chk_int("dir_latency", 0, lat, 8);
        end

        // Back-pressure: result held 5 cycles, then returned to IDLE
        send(0, 64'h07, 5, p, lat);
        chk("bp_parity", 0, p, 1'b1);
        chk("bp_idle_ready", 0, d_in_ready[0], 1'b1);

        // Odd parity variant
        send(1, 64'h00, 0, p, lat);
        chk("odd_00", 1, p, 1'b1);
        send(1, 64'h01, 0, p, lat);
        chk("odd_01", 1, p, 1'b0);

        // Single-bit word
        send(2, 64'h1, 0, p, lat);
        chk("w1_one", 2, p, 1'b1);
        chk_int("w1_latency", 2, lat, 1);
        send(2, 64'h0, 0, p, lat);
        chk("w1_zero", 2, p, 1'b0);

        // in_valid held high with data changing every cycle
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            in_valid[0]  = 1'b1;
            in_data[0]   = 64'($urandom_range(0, 255));
            out_ready[0] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        repeat (12) @(negedge clk);
        out_ready[0] = 1'b0;

        // Reset in the middle of SHIFT
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 64'hFF;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 0, d_in_ready[0], 1'b1);
        chk("mid_rst_out_valid", 0, d_out_valid[0], 1'b0);
        chk("mid_rst_busy", 0, d_busy[0], 1'b0);
        chk("mid_rst_parity", 0, d_out_parity[0], 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (d_out_valid[0]) n++;
        end
        chk_int("no_valid_after_rst", 0, n, 0);
        send(0, 64'h03, 0, p, lat);
        chk("after_rst_03", 0, p, 1'b0);

        // Random traffic on all three
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                in_valid[k]  = 1'($urandom_range(0, 1));
                in_data[k]   = {32'($urandom), 32'($urandom)};
                out_ready[k] = ($urandom_range(0, 3) != 0);
            end
        end
        idle_all();
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
